// File: rtl/ccl_window_gen.sv
// ccl_window_gen: raster-scan neighbourhood generator for connected-component labelling.
// Presents A (up-left), B (up), C (up-right) and D (left) labels for the current
// pixel from a one-row label line buffer, and tracks col/row with eol/eof flags.
// Optional macro CCL_WINDOW_8CONN_EN: defined -> 8-connectivity (A and C generated),
// undefined -> 4-connectivity (A and C tied to 0, a_reg and C read port removed).

`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

module ccl_window_gen #(
    parameter int WORD_SIZE  = `WORD_SIZE,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    localparam int CW = $clog2(IMG_WIDTH),
    localparam int RW = $clog2(IMG_HEIGHT)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic                 sof,
    input  logic [WORD_SIZE-1:0] label_in,
    output logic [WORD_SIZE-1:0] A,
    output logic [WORD_SIZE-1:0] B,
    output logic [WORD_SIZE-1:0] C,
    output logic [WORD_SIZE-1:0] D,
    output logic [CW-1:0]        col,
    output logic [RW-1:0]        row,
    output logic                 eol,
    output logic                 eof
);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    // Line buffer holds the previous row's labels; never reset, row-0 gating hides stale data.
    logic [WORD_SIZE-1:0] line_buf [IMG_WIDTH];

    logic [CW-1:0]        col_q;
    logic [RW-1:0]        row_q;
    logic [WORD_SIZE-1:0] d_reg;
`ifdef CCL_WINDOW_8CONN_EN
    logic [WORD_SIZE-1:0] a_reg;
    logic [CW-1:0]        c_idx;
`endif

    // sof only counts when a pixel is actually presented.
    logic          sof_en;
    logic [CW-1:0] cur_col;
    logic [RW-1:0] cur_row;
    logic          first_col, last_col, first_row, last_row;

    // Effective position of the current pixel and the boundary decodes.
    always_comb begin
        sof_en    = en & sof;
        cur_col   = sof_en ? '0 : col_q;
        cur_row   = sof_en ? '0 : row_q;
        first_col = (cur_col == '0);
        last_col  = (cur_col == COL_LAST);
        first_row = (cur_row == '0);
        last_row  = (cur_row == ROW_LAST);
    end

    // Neighbour labels: buffer reads happen before this cycle's overwrite.
    always_comb begin
        B   = first_row ? '0 : line_buf[cur_col];
        D   = first_col ? '0 : d_reg;
`ifdef CCL_WINDOW_8CONN_EN
        // Keep the C read index in range on the last column; the value is masked anyway.
        c_idx = last_col ? '0 : cur_col + CW'(1);
        A     = (first_row || first_col) ? '0 : a_reg;
        C     = (first_row || last_col) ? '0 : line_buf[c_idx];
`else
        A     = '0;
        C     = '0;
`endif
        col = cur_col;
        row = cur_row;
        eol = last_col;
        eof = last_col && last_row;
    end

    // Position counters and the A/D history registers advance on accepted pixels.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q <= '0;
            row_q <= '0;
            d_reg <= '0;
`ifdef CCL_WINDOW_8CONN_EN
            a_reg <= '0;
`endif
        end else if (en) begin
            if (last_col) begin
                col_q <= '0;
                row_q <= last_row ? '0 : cur_row + RW'(1);
            end else begin
                col_q <= cur_col + CW'(1);
                row_q <= cur_row;
            end
            d_reg <= label_in;
`ifdef CCL_WINDOW_8CONN_EN
            // Today's B is tomorrow's A (one column to the right).
            a_reg <= B;
`endif
        end
    end

    // Overwrite the current column with the freshly assigned label.
    always_ff @(posedge clk) begin
        if (en) line_buf[cur_col] <= label_in;
    end

endmodule
